// File: rtl/ads_dout_rx_if.sv
// Avalon-MM slave bus bundle for the ADS7843 conversion engine.
interface ads_dout_rx_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );
endinterface

// File: rtl/ads_dout_rx.sv
// ADS7843 touch-controller conversion engine behind an Avalon-MM slave.
// Define ADS_DOUT_IRQ_EN to build the IE bit and the registered pen/done interrupt.
module ads_dout_rx #(
  parameter int unsigned CLKDIV_RST = 25,
  parameter int unsigned DIV_W      = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  ads_dout_rx_if.slave bus,
  output logic         ads_cs_n,
  output logic         ads_dclk,
  output logic         ads_din,
  input  logic         ads_dout,
  input  logic         ads_penirq_n,
  output logic         irq
);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, h_q, h_d, clkdiv_q, clkdiv_d, h_eff;
  logic [4:0]         per_q, per_d;
  logic               phase_q, phase_d;
  logic [11:0]        shift_q, shift_d, result_q, result_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               valid_q, valid_d, ovr_q, ovr_d, drop_q, drop_d;
  logic               cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
  logic [1:0]         dout_sync_q, pen_sync_q;
  logic               wr, rd, data_rd, status_wr, cmd_wr, last, done, busy, pen, ie;

  assign wr        = bus.chipselect & ~bus.write_n;
  assign rd        = bus.chipselect & ~bus.read_n;
  assign data_rd   = rd & (bus.address == 2'd0);
  assign cmd_wr    = wr & (bus.address == 2'd1);
  assign status_wr = wr & (bus.address == 2'd2);
  assign busy      = (state_q != StIdle);
  assign pen       = ~pen_sync_q[1];
  assign last      = (cnt_q == h_q - DIV_W'(1));
  // Half periods below 3 would starve the two-flop DOUT synchronizer.
  assign h_eff     = (clkdiv_q < DIV_W'(3)) ? DIV_W'(3) : clkdiv_q;

  assign ads_cs_n  = cs_n_q;
  assign ads_dclk  = dclk_q;
  assign ads_din   = din_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + DIV_W'(1);
    h_d      = h_q;
    per_d    = per_q;
    phase_d  = phase_q;
    shift_d  = shift_q;
    result_d = result_q;
    cmd_d    = cmd_q;
    cs_n_d   = cs_n_q;
    dclk_d   = dclk_q;
    din_d    = din_q;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cmd_wr) begin
          state_d = StSetup;
          cs_n_d  = 1'b0;
          h_d     = h_eff;
          cmd_d   = bus.writedata[7:0];
        end
      end
      StSetup: begin
        if (last) begin
          state_d = StShift;
          cnt_d   = '0;
          per_d   = '0;
          phase_d = 1'b0;
          din_d   = cmd_q[7];
        end
      end
      StShift: begin
        if (last) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            dclk_d  = 1'b1;
          end else begin
            // Periods 10..21 (zero-based 9..20) carry result bits 11..0.
            if (per_q inside {[5'd9:5'd20]}) shift_d = {shift_q[10:0], dout_sync_q[1]};
            phase_d = 1'b0;
            dclk_d  = 1'b0;
            if (per_q == 5'd23) begin
              state_d = StHold;
              din_d   = 1'b0;
            end else begin
              per_d = per_q + 5'd1;
              din_d = (per_q < 5'd7) ? cmd_q[3'd6 - per_q[2:0]] : 1'b0;
            end
          end
        end
      end
      StHold: begin
        if (last) begin
          state_d  = StIdle;
          cnt_d    = '0;
          cs_n_d   = 1'b1;
          result_d = shift_q;
          done     = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status flags: a completing conversion wins over a same-cycle clear.
  always_comb begin
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    drop_d   = drop_q;
    clkdiv_d = clkdiv_q;
    if (data_rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (status_wr && bus.writedata[2]) ovr_d = 1'b0;
    if (status_wr && bus.writedata[3]) drop_d = 1'b0;
    if (cmd_wr && busy) drop_d = 1'b1;
    if (done) begin
      valid_d = 1'b1;
      if (valid_q) ovr_d = 1'b1;
    end
    if (wr && (bus.address == 2'd3)) clkdiv_d = bus.writedata[DIV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      h_q         <= DIV_W'(3);
      per_q       <= '0;
      phase_q     <= 1'b0;
      shift_q     <= '0;
      result_q    <= '0;
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      drop_q      <= 1'b0;
      clkdiv_q    <= DIV_W'(CLKDIV_RST);
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      dout_sync_q <= '0;
      pen_sync_q  <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      h_q         <= h_d;
      per_q       <= per_d;
      phase_q     <= phase_d;
      shift_q     <= shift_d;
      result_q    <= result_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      drop_q      <= drop_d;
      clkdiv_q    <= clkdiv_d;
      cs_n_q      <= cs_n_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      dout_sync_q <= {dout_sync_q[0], ads_dout};
      pen_sync_q  <= {pen_sync_q[0], ads_penirq_n};
    end
  end

`ifdef ADS_DOUT_IRQ_EN
  logic ie_q, irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (status_wr) ie_q <= bus.writedata[8];
      irq_q <= (ie_q & valid_q) | (ie_q & pen & ~busy);
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata = {16'h0, valid_q, 3'b000, result_q};
      2'd1: bus.readdata = {24'h0, cmd_q};
      2'd2: bus.readdata = {23'h0, ie, 3'b000, pen, drop_q, ovr_q, valid_q, busy};
      2'd3: bus.readdata = 32'(clkdiv_q);
      default: bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ads_dout_rx.sv
// Randomized self-checking bench for ads_dout_rx with a behavioural ADS7843 pin model.
module tb_ads_dout_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ads_cs_n, ads_dclk, ads_din, irq;
  logic ads_dout = 1'b0;
  logic ads_penirq_n = 1'b1;

  int checks = 0;
  int errors = 0;
  int irq_high = 0;

  // Device model state
  logic [11:0] dev_val = '0;
  int          rise_cnt = 0;
  logic [7:0]  din_cap = '0;
  int          din_late_ones = 0;
  logic        prev_dclk = 1'b0;
  logic        prev_cs = 1'b1;

  ads_dout_rx_if bus ();

  ads_dout_rx #(
    .CLKDIV_RST(25),
    .DIV_W     (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .ads_cs_n    (ads_cs_n),
    .ads_dclk    (ads_dclk),
    .ads_din     (ads_din),
    .ads_dout    (ads_dout),
    .ads_penirq_n(ads_penirq_n),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int h_of(input int div);
    return (div < 3) ? 3 : div;
  endfunction

  // ADS7843 pins: latch DIN on DCLK rise, present result bit p on the fall before period p.
  initial begin
    int p;
    forever begin
      @(ads_dclk or ads_cs_n);
      if (prev_cs && ads_cs_n === 1'b0) begin
        rise_cnt = 0;
        din_cap = '0;
        din_late_ones = 0;
      end
      if (!prev_dclk && ads_dclk === 1'b1 && ads_cs_n === 1'b0) begin
        rise_cnt++;
        if (rise_cnt <= 8) din_cap = {din_cap[6:0], ads_din};
        else if (ads_din !== 1'b0) din_late_ones++;
      end
      if (prev_dclk && ads_dclk === 1'b0 && ads_cs_n === 1'b0) begin
        p = rise_cnt + 1;
        if (p >= 10 && p <= 21) ads_dout = dev_val[21-p];
        else ads_dout = 1'($urandom);
      end
      prev_dclk = (ads_dclk === 1'b1);
      prev_cs   = (ads_cs_n !== 1'b0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && irq !== 1'b0) irq_high++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #2;
    data = bus.readdata;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
  endtask

  // Start a conversion, count BUSY cycles, and check the pin-level transaction.
  task automatic run_conv(input logic [7:0] cmd, input logic [11:0] val, input int h,
                          input bit drop_mid);
    logic [31:0] s;
    int n = 0;
    dev_val = val;
    bus_write(2'd1, {24'h0, cmd});
    check_eq("cs_n_falls_with_busy", ads_cs_n, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      if (drop_mid && n == 20) begin
        bus_write(2'd1, 32'hD0);
        n++;
        continue;
      end
      bus_read(2'd2, s);
      if (!s[0]) break;
      n++;
    end
    check_eq("busy_cycles", n, 50 * h);
    check_eq("din_command", din_cap, cmd);
    check_eq("dclk_periods", rise_cnt, 24);
    check_eq("din_zero_tail", din_late_ones, 0);
    check_eq("cs_n_idle", ads_cs_n, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  cmd;
    logic [11:0] v1, v2;
    int          div, h;

    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.read_n = 1'b1; bus.writedata = '0;
    step(3);
    reset_n = 1'b1;
    step(1);

    // Reset state
    check_eq("rst_cs_n", ads_cs_n, 1'b1);
    check_eq("rst_dclk", ads_dclk, 1'b0);
    check_eq("rst_irq", irq, 1'b0);
    bus_read(2'd0, d); check_eq("rst_data", d, 32'h0);
    bus_read(2'd1, d); check_eq("rst_cmd", d, 32'h0);
    bus_read(2'd2, d); check_eq("rst_status", d, 32'h0);
    bus_read(2'd3, d); check_eq("rst_clkdiv", d, 32'd25);

    // Directed conversion
    bus_write(2'd3, 32'd4);
    run_conv(8'h90, 12'hA5C, 4, 1'b0);
    bus_read(2'd0, d); check_eq("data_first_read", d, 32'h0000_8A5C);
    bus_read(2'd0, d); check_eq("data_second_read", d, 32'h0000_0A5C);

    // CMD write while busy is dropped
    run_conv(8'h90, 12'h3C1, 4, 1'b1);
    bus_read(2'd1, d); check_eq("cmd_unchanged", d, 32'h90);
    bus_read(2'd2, d); check_eq("drop_set", d[3], 1'b1);
    bus_write(2'd2, 32'h8);
    bus_read(2'd2, d); check_eq("drop_cleared", d[3], 1'b0);
    bus_read(2'd0, d); check_eq("drop_run_data", d, 32'h8000 | 32'h3C1);

    // Overrun handling
    v1 = 12'($urandom); v2 = 12'($urandom);
    run_conv(8'hD3, v1, 4, 1'b0);
    run_conv(8'h93, v2, 4, 1'b0);
    bus_read(2'd2, d); check_eq("ovr_status", d, 32'h6);
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, d); check_eq("ovr_w1c", d, 32'h2);
    bus_read(2'd0, d); check_eq("ovr_second_data", d, 32'h8000 | 32'(v2));
    bus_read(2'd2, d); check_eq("ovr_read_clear1", d, 32'h0);
    run_conv(8'hA1, v1, 4, 1'b0);
    run_conv(8'hA2, v2, 4, 1'b0);
    bus_read(2'd2, d); check_eq("ovr_status2", d, 32'h6);
    bus_read(2'd0, d); check_eq("ovr_second_data2", d, 32'h8000 | 32'(v2));
    bus_read(2'd2, d); check_eq("ovr_read_clear2", d, 32'h0);

    // Randomized conversions, including divisors below the floor of 3
    for (int k = 0; k < 5; k++) begin
      div = int'($urandom_range(0, 6));
      h   = h_of(div);
      cmd = 8'($urandom);
      v1  = 12'($urandom);
      bus_write(2'd3, 32'(div));
      bus_read(2'd3, d); check_eq("rand_clkdiv", d, 32'(div));
      run_conv(cmd, v1, h, 1'b0);
      bus_read(2'd0, d); check_eq("rand_data", d, 32'h8000 | 32'(v1));
      bus_read(2'd0, d); check_eq("rand_data_reread", d, 32'(v1));
    end

    // DATA read on the edge VALID sets: set wins, OVR judged on pre-read VALID
    bus_write(2'd3, 32'd3);
    v1 = 12'($urandom); v2 = 12'($urandom);
    run_conv(8'hB0, v1, 3, 1'b0);
    dev_val = v2;
    bus_write(2'd1, 32'hB1);
    step(50 * 3 - 1);
    bus_read(2'd0, d); check_eq("edge_read_old", d, 32'h8000 | 32'(v1));
    bus_read(2'd2, d); check_eq("edge_read_status", d, 32'h6);
    bus_read(2'd0, d); check_eq("edge_read_new", d, 32'h8000 | 32'(v2));

    // CMD write on the edge HOLD completes is dropped
    v1 = 12'($urandom);
    dev_val = v1;
    bus_write(2'd1, 32'hC4);
    step(50 * 3 - 1);
    bus_write(2'd1, 32'h55);
    bus_read(2'd2, d); check_eq("hold_edge_drop", d, 32'hA);
    bus_read(2'd1, d); check_eq("hold_edge_cmd", d, 32'hC4);
    step(10);
    bus_read(2'd2, d); check_eq("hold_edge_idle", d, 32'hA);
    bus_write(2'd2, 32'h8);
    bus_read(2'd0, d); check_eq("hold_edge_data", d, 32'h8000 | 32'(v1));

    // PEN synchronizer and IE
    ads_penirq_n = 1'b0;
    step(3);
    bus_read(2'd2, d); check_eq("pen_status", d, 32'h10);
    bus_write(2'd2, 32'h100);
`ifdef ADS_DOUT_IRQ_EN
    bus_read(2'd2, d); check_eq("ie_status", d, 32'h110);
    step(2);
    check_eq("irq_pen", irq, 1'b1);
    dev_val = 12'h123;
    bus_write(2'd1, 32'h90);
    step(5);
    check_eq("irq_busy_low", irq, 1'b0);
    step(50 * 3);
    check_eq("irq_valid", irq, 1'b1);
    bus_read(2'd0, d); check_eq("irq_data", d, 32'h8123);
    ads_penirq_n = 1'b1;
    step(5);
    check_eq("irq_cleared", irq, 1'b0);
    bus_write(2'd2, 32'h0);
`else
    bus_read(2'd2, d); check_eq("ie_absent", d, 32'h10);
    dev_val = 12'h123;
    bus_write(2'd1, 32'h90);
    step(50 * 3 + 5);
    bus_read(2'd0, d); check_eq("noirq_data", d, 32'h8123);
    check_eq("irq_never_high", irq_high, 0);
`endif
    ads_penirq_n = 1'b1;
    step(3);

    // Reset in DCLK period 12
    bus_write(2'd3, 32'd5);
    dev_val = 12'hFFF;
    bus_write(2'd1, 32'h90);
    for (int i = 0; i < 3000; i++) begin
      if (rise_cnt >= 12) break;
      step(1);
    end
    check_eq("reached_period12", rise_cnt, 12);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    check_eq("midrst_cs_n", ads_cs_n, 1'b1);
    check_eq("midrst_dclk", ads_dclk, 1'b0);
    check_eq("midrst_din", ads_din, 1'b0);
    step(400);
    bus_read(2'd2, d); check_eq("midrst_status", d, 32'h0);
    bus_read(2'd0, d); check_eq("midrst_data", d, 32'h0);
    bus_read(2'd3, d); check_eq("midrst_clkdiv", d, 32'd25);
    check_eq("midrst_irq", irq, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ads_dout_rx.md
# ads_dout_rx

Avalon-MM slave that runs complete ADS7843 touch-controller conversions, serializing the command onto DIN and capturing the 12-bit result returned on DOUT. It replaces bit-banged PIO access to the touch controller's serial pins in the TFT/SD Nios system. It owns CS_N, DCLK and DIN, samples DOUT/PENIRQ_N, and presents the result, status and an optional pen/done interrupt to the CPU.

## Interface
- `CLKDIV_RST`, default 25: reset value of the DCLK half-period register, in `clk` cycles.
- `DIV_W`, default 16: width of the half-period register and its counter.
- `clk` in 1: system clock. All logic sits in this single clock domain.
- `reset_n` in 1: reset is synchronous and active-low.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `read_n` in 1: active-low read strobe. It drives read side effects only.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read mux of `address`.
- `ads_cs_n` out 1: ADS7843 chip select. Reset value 1.
- `ads_dclk` out 1: serial clock. Reset value 0.
- `ads_din` out 1: command bit to the device. Reset value 0.
- `ads_dout` in 1: device data, asynchronous.
- `ads_penirq_n` in 1: pen-down, active low, asynchronous.
- `irq` out 1: interrupt. Reset value 0.

## Operation
**Registers.** Accesses are `chipselect` plus a strobe. Unused bits read as 0.
- **0 DATA** (read)
  - [11:0] = last result; [15] = VALID.
  - A read clears VALID and OVR.
- **1 CMD**
  - Write [7:0] = command byte. The write starts a transaction only if the FSM is IDLE; otherwise it is ignored and CMD_DROP is set.
  - Read returns the last accepted command.
- **2 STATUS**
  - [0] BUSY.
  - [1] VALID.
  - [2] OVR, set when a result lands while VALID=1. The new data overwrites the old.
  - [3] CMD_DROP.
  - [4] PEN = synchronized `~ads_penirq_n`.
  - [8] IE.
  - Writing 1 to bit 2 clears OVR; writing 1 to bit 3 clears CMD_DROP; bit 8 is written directly.
- **3 CLKDIV**
  - [DIV_W-1:0] = half-period H, in `clk` cycles.
  - Values below 3 behave as 3.
  - Writes while BUSY take effect at the next transaction.

**Synchronizers.** `ads_dout` and `ads_penirq_n` each pass through 2 flops.

**FSM states**
- **IDLE**: `ads_cs_n`=1, DCLK=0. An accepted CMD write moves to SETUP.
- **SETUP**: CS_N=0 for H cycles, then SHIFT.
- **SHIFT**: 24 DCLK periods; each is H cycles low then H cycles high.
  - DIN carries command bits 7..0, MSB first, changing at the start of each low phase for periods 1–8. It is 0 for periods 9–24.
  - Synchronized DOUT is sampled in the last `clk` cycle of the high phase of periods 10–21, filling result bits 11..0.
  - After period 24 the FSM moves to HOLD.
- **HOLD**: CS_N=0, DCLK=0 for H cycles. Then the result is latched, VALID=1, and the FSM returns to IDLE.

**Boundary cases**
- A DATA read in the same cycle that VALID sets: the set wins, so VALID=1 afterwards, and OVR is evaluated against the pre-read VALID.
- Reset asserted mid-transaction: on the next edge all outputs take their reset values (CS_N=1 immediately) and the FSM goes to IDLE. No partial result is latched.
- CMD write in the same cycle that HOLD completes: the write is dropped (the FSM is not yet IDLE).

## Timing
- BUSY rises 1 cycle after the accepted CMD write.
- `ads_cs_n` falls in that same cycle.
- BUSY clears and VALID sets on the same edge, exactly 50·H cycles after BUSY rises.
- DCLK is registered, with no combinational path from `clk`.
- `readdata` is zero-wait combinational.
- PEN lags the pin by 2 cycles.

## Configuration
- **`ADS_DOUT_IRQ_EN` defined:**
  - `irq` is registered: (IE & VALID) | (IE & PEN & ~BUSY).
  - It is cleared by clearing the cause.
- **`ADS_DOUT_IRQ_EN` undefined:**
  - `irq` is tied to 0.
  - STATUS[8] reads 0 and ignores writes.
  - No IE flop exists.

## Test plan
- Reset, then read all registers: 0x0, 0x0, 0x0 (or 0x10 with the pen held down), CLKDIV=25. Pins: `ads_cs_n`=1, `ads_dclk`=0, `irq`=0.
- CLKDIV=4; write CMD=0x90; the DOUT model returns 0xA5C.
  - DIN shows 1,0,0,1,0,0,0,0 on the first 8 rising edges.
  - BUSY lasts 200 cycles.
  - DATA reads 0x00008A5C; a second read returns 0x00000A5C.
- CMD write while BUSY (0xD0 during a 0x90 run): the transaction is unchanged, STATUS[3]=1, and writing 0x8 clears it.
- Two conversions without reading DATA: STATUS=0x6 and DATA holds the second result. Then:
  - writing 0x4 to STATUS clears OVR;
  - a DATA read clears both VALID and OVR.
- Assert `reset_n`=0 for 1 cycle at DCLK period 12: `ads_cs_n`=1 on the next edge, and no VALID results.
- With `ADS_DOUT_IRQ_EN`: IE=1, PEN low → `irq`=1; start a conversion → `irq` drops while BUSY and reasserts with VALID. Without the macro, `irq` stays 0 throughout.
